dummy_top: RTL and testbench
============================

// Module: dummy_top
//
// PURPOSE
// - Arty board bring-up top: proves clock, reset and UART TX pin are alive with no host input.
// - After reset, repeatedly transmits a fixed ASCII banner "MSPU alive\r\n" on uart_tx (8N1).
// - Stand-in top level until the MSPU core is integrated; no inputs besides clk/reset.
//
// PARAMETERS
// - CLK_HZ        100_000_000  input clock frequency in Hz
// - BAUD          115_200      UART bit rate
// - CLKS_PER_BIT  CLK_HZ/BAUD  clocks per UART bit, integer-truncated (868 by default); must be >= 2
// - GAP_CYCLES    1_000_000    idle-high clocks between end of one banner and start of the next
//
// PORTS
// - clk      in   1  single system clock, all logic on rising edge
// - reset    in   1  synchronous, active-high reset
// - uart_tx  out  1  UART serial output, idle high, registered (no combinational path)
//
// BEHAVIOUR
// - Reset: uart_tx=1; byte index=0; bit/baud counters=0; sequencer in LOAD.
// - Frame: start bit 0, 8 data bits LSB first, stop bit 1; every bit exactly CLKS_PER_BIT clocks.
// - Banner ROM, 12 bytes, index 0..11:
//   4D 53 50 55 20 61 6C 69 76 65 0D 0A.
// - Sequencer states: LOAD -> SEND -> (next byte: LOAD | last byte: GAP) -> LOAD.
//   - LOAD: present ROM[index] to the TX with a 1-cycle start pulse.
//   - SEND: wait for TX done.
//   - GAP: count GAP_CYCLES with uart_tx=1, then index=0.
// - Start timing: let edge N be the first rising edge that samples reset=0.
//   - Start bit of byte 0 drives uart_tx=0 from edge N+1.
// - Bytes within a banner are back-to-back:
//   - Next start bit begins on the clock immediately after the previous stop bit's last clock.
//   - No extra idle between bytes.
// - Between banners: exactly GAP_CYCLES clocks high after the final stop bit, then the next start bit.
// - Index wraps 11 -> 0 only via GAP; banner content never varies.
// - Reset at any time, including mid-bit or mid-gap:
//   - uart_tx=1 at that edge; all state cleared.
//   - After release, restart from byte 0 with the same N+1 timing.
// - Counter widths: $clog2 of CLKS_PER_BIT and GAP_CYCLES (min 1 bit); no overflow in legal configurations.
//
// STRUCTURE
// - Package dummy_top_pkg:
//   - MSG_LEN=12; banner ROM as localparam logic [7:0] MSG [MSG_LEN].
//   - Sequencer enum {LOAD, SEND, GAP}; TX enum {IDLE, START, DATA, STOP}.
// - Sub-module uart_tx_8n1 (params CLKS_PER_BIT):
//   - Inputs: clk, reset, start, data[7:0]. Outputs: tx, busy, done (1-cycle pulse).
//   - tx registered and driven low on the edge that samples start.
//   - done pulses on the last clock of the stop bit, so a start issued in the following cycle gives a gapless frame.
//   - Lets LOAD+SEND meet the back-to-back requirement: the sequencer issues start on the done cycle.
// - dummy_top: instantiates uart_tx_8n1, ROM index counter, gap counter, sequencer FSM.
//
// TESTING (bench: 10 ns clock; reset high for 20 clocks, then low)
// - Bench configuration: override CLK_HZ=1_600, BAUD=200 (CLKS_PER_BIT=8), GAP_CYCLES=50.
// - Reset held 20 clocks -> uart_tx=1 every cycle of reset.
// - Release reset -> UART decoder reads exactly 4D 53 50 55 20 61 6C 69 76 65 0D 0A; every stop bit=1.
// - Timing -> first falling edge of uart_tx at N+1.
//   - Each bit 8 clocks; byte frame 80 clocks; banner 960 clocks with no idle between bytes.
// - Repeat -> after the 0x0A stop bit, uart_tx high exactly 50 clocks, then second banner identical to first.
// - Reset pulsed 3 clocks during data bit 4 of byte 3 (0x55):
//   - uart_tx=1 during reset.
//   - After release, first decoded byte is 0x4D at N+1.
// - Default parameters, short run -> start bit of byte 0 lasts exactly 868 clocks.

Source files
------------

// File: rtl/dummy_top_pkg.sv
// Shared types and constants for the board bring-up top.
// Holds the banner ROM contents, the sequencer and UART TX state encodings.
package dummy_top_pkg;

  localparam int unsigned MSG_LEN = 12;

  // "MSPU alive\r\n"
  localparam logic [7:0] MSG [MSG_LEN] = '{
    8'h4D, 8'h53, 8'h50, 8'h55, 8'h20, 8'h61,
    8'h6C, 8'h69, 8'h76, 8'h65, 8'h0D, 8'h0A
  };

  typedef enum logic [1:0] {LOAD, SEND, GAP} seq_state_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   start       - sampled each edge while idle or on the last stop-bit clock
//   data[7:0]   - byte captured on the edge that samples start
//   tx          - registered serial line, idle high
//   busy        - high while a frame is in progress
//   done        - one-cycle pulse on the last clock of the stop bit
// A start presented during the done cycle chains the next frame with no idle gap.
module uart_tx_8n1
  import dummy_top_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          cnt_d   = '0;
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // done is registered, so raise it one clock early to land on the last stop clock
        done_d = (cnt_q == CNT_PRE);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (start) begin
            state_d = START;
            shreg_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/dummy_top.sv
// Arty bring-up top: after reset, repeatedly sends "MSPU alive\r\n" on uart_tx
// (8N1), with GAP_CYCLES idle-high clocks between banners. GAP_CYCLES must be >= 2.
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset
//   uart_tx  - registered UART serial output, idle high
module dummy_top
  import dummy_top_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned GAP_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic uart_tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned IDX_W = $clog2(MSG_LEN);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
  // GAP holds for GAP_CYCLES-1 clocks; the LOAD clock that follows completes the gap
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_CYCLES - 2);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ready_q;
  logic             start_c;
  logic [7:0]       data_c;
  logic             tx_busy;
  logic             tx_done;

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (start_c),
    .data  (data_c),
    .tx    (uart_tx),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  // Sequencer registers; ready_q holds off the first start for one clock after reset release
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      index_q <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      gap_q   <= gap_d;
      ready_q <= 1'b1;
    end
  end

  // Sequencer next state; the next byte is started in the done cycle to keep frames gapless
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    gap_d   = gap_q;
    start_c = 1'b0;
    data_c  = MSG[index_q];

    unique case (state_q)
      LOAD: begin
        if (ready_q && !tx_busy) begin
          start_c = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_done) begin
          if (index_q == LAST_IDX) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            index_d = index_q + IDX_W'(1);
            data_c  = MSG[index_d];
            start_c = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_END) begin
          state_d = LOAD;
          index_d = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_dummy_top.sv
// Bench for dummy_top: reduced-rate instance checked cycle by cycle against an
// arithmetic waveform model, plus a default-parameter instance for start-bit length.
module tb_dummy_top;

  localparam int CPB     = 8;
  localparam int GAPC    = 50;
  localparam int FRAME   = 10 * CPB;
  localparam int BANNER  = 12 * FRAME;
  localparam int PERIOD  = BANNER + GAPC;
  localparam int DEF_CPB = 868;
  localparam int WAVE_N  = 2200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_tx;
  logic uart_tx_def;

  int n_vec = 0;
  int n_err = 0;
  int k = -1;
  logic wave [WAVE_N];
  logic [7:0] banner [12] = '{8'h4D, 8'h53, 8'h50, 8'h55, 8'h20, 8'h61,
                              8'h6C, 8'h69, 8'h76, 8'h65, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  dummy_top #(.CLK_HZ(1_600), .BAUD(200), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .reset(reset), .uart_tx(uart_tx)
  );

  dummy_top u_def (
    .clk(clk), .reset(reset), .uart_tx(uart_tx_def)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
    end
  endtask

  // Expected line level after the k-th edge since release (edge N is k=0)
  function automatic logic exp_tx(input int kk);
    int p, byt, b;
    logic [7:0] v;
    if (kk <= 0) return 1'b1;
    p = (kk - 1) % PERIOD;
    if (p >= BANNER) return 1'b1;
    byt = p / FRAME;
    b = (p % FRAME) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    v = banner[byt];
    return v[b-1];
  endfunction

  task automatic step(input logic rst);
    reset = rst;
    @(posedge clk);
    if (rst) k = -1; else k = k + 1;
    @(negedge clk);
    chk("tx", {7'd0, uart_tx}, {7'd0, exp_tx(k)});
    if (k >= 0 && k < WAVE_N) wave[k] = uart_tx;
    if (k >= 0 && k <= DEF_CPB + 1)
      chk("def_start", {7'd0, uart_tx_def}, {7'd0, (k >= 1 && k <= DEF_CPB) ? 1'b0 : 1'b1});
  endtask

  // Mid-bit decoder over the recorded waveform; base is k of the start bit's first clock
  task automatic decode(input int base, input int idx, input string tag);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = wave[base + CPB * (i + 1) + CPB / 2];
    chk({tag, "_start"}, {7'd0, wave[base + CPB / 2]}, 8'd0);
    chk({tag, "_byte"}, b, banner[idx]);
    chk({tag, "_stop"}, {7'd0, wave[base + 9 * CPB + CPB / 2]}, 8'd1);
  endtask

  initial begin
    int guard;
    // Reset held 20 clocks
    for (int i = 0; i < 20; i++) step(1'b1);

    // Two banners plus gap
    for (int i = 0; i < 2100; i++) step(1'b0);
    for (int i = 0; i < 12; i++) decode(1 + i * FRAME, i, "b1");
    for (int i = 0; i < 12; i++) decode(1 + PERIOD + i * FRAME, i, "b2");

    // Reset during data bit 4 of byte 3
    step(1'b1);
    step(1'b1);
    guard = 0;
    while (k != 3 * FRAME + 5 * CPB + 1 && guard < 5000) begin
      step(1'b0);
      guard++;
    end
    chk("run_to_bit4", {7'd0, guard < 5000}, 8'd1);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 100; i++) step(1'b0);
    decode(1, 0, "after_rst");

    // Random reset pulses at random points
    for (int r = 0; r < 5; r++) begin
      int run_len = int'($urandom_range(30, 2500));
      int rst_len = int'($urandom_range(1, 5));
      for (int i = 0; i < run_len; i++) step(1'b0);
      for (int i = 0; i < rst_len; i++) step(1'b1);
    end
    for (int i = 0; i < 200; i++) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
